// File: rtl/counter_param.sv
// Parameterised up/down counter with load, wrap-or-saturate boundary handling,
// a terminal-count pulse and a sticky boundary-event flag.
module counter_param #(
    parameter int          WIDTH   = 4,
    parameter int unsigned MAX_VAL = 15,
    parameter int unsigned RST_VAL = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up_dn,
    input  logic             sat_mode,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             clr_ovf,
    output logic [WIDTH-1:0] out,
    output logic             tc,
    output logic             ovf,
    output logic             at_max,
    output logic             at_zero
);

    localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MAX_VAL);
    localparam logic [WIDTH-1:0] RST_C = WIDTH'(RST_VAL);
    localparam logic [WIDTH-1:0] ONE_C = WIDTH'(1);

    // Loads above the count range are pinned to the top of the range.
    function automatic logic [WIDTH-1:0] clamp_load(input logic [WIDTH-1:0] v);
        return (v > MAX_C) ? MAX_C : v;
    endfunction

    function automatic logic [WIDTH-1:0] boundary_next(
        input logic [WIDTH-1:0] cur,
        input logic             up,
        input logic             sat
    );
        if (sat)
            return cur;
        return up ? '0 : MAX_C;
    endfunction

    logic             boundary;
    logic [WIDTH-1:0] out_next;
    logic             tc_next;
    logic             ovf_next;

    assign boundary = en && !load &&
                      ((up_dn && (out == MAX_C)) || (!up_dn && (out == '0)));

    always_comb begin
        out_next = out;
        tc_next  = 1'b0;
        ovf_next = ovf;

        if (load) begin
            out_next = clamp_load(load_val);
        end else if (boundary) begin
            out_next = boundary_next(out, up_dn, sat_mode);
            tc_next  = 1'b1;
        end else if (en) begin
            // Non-boundary steps stay inside 0..MAX_C, so no width overflow here.
            out_next = up_dn ? (out + ONE_C) : (out - ONE_C);
        end

        // A boundary event wins over a simultaneous clear.
        if (boundary)
            ovf_next = 1'b1;
        else if (clr_ovf)
            ovf_next = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out <= RST_C;
            tc  <= 1'b0;
            ovf <= 1'b0;
        end else begin
            out <= out_next;
            tc  <= tc_next;
            ovf <= ovf_next;
        end
    end

    assign at_max  = (out == MAX_C);
    assign at_zero = (out == '0);

endmodule

// File: tb/tb_counter_param.sv
// Randomised and directed bench for counter_param: a 4-bit/MAX 9 instance and an
// 8-bit/MAX 255/reset 250 instance, both compared against an integer model.
module tb_counter_param;

    localparam int MAXV  = 9;
    localparam int MAXV8 = 255;
    localparam int RST8  = 250;

    logic       clk = 1'b0;
    logic       rst, en, up_dn, sat_mode, load, clr_ovf;
    logic [3:0] load_val;
    logic [3:0] out;
    logic       tc, ovf, at_max, at_zero;

    logic       en8;
    logic [7:0] out8;
    logic       tc8, ovf8, at_max8, at_zero8;

    int checks = 0;
    int errors = 0;

    int m_out, m_tc, m_ovf;
    int m8_out, m8_tc;

    always #5 clk = ~clk;

    counter_param #(.WIDTH(4), .MAX_VAL(9), .RST_VAL(0)) dut (
        .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .sat_mode(sat_mode),
        .load(load), .load_val(load_val), .clr_ovf(clr_ovf),
        .out(out), .tc(tc), .ovf(ovf), .at_max(at_max), .at_zero(at_zero)
    );

    counter_param #(.WIDTH(8), .MAX_VAL(255), .RST_VAL(250)) dut8 (
        .clk(clk), .rst(rst), .en(en8), .up_dn(1'b1), .sat_mode(1'b0),
        .load(1'b0), .load_val(8'd0), .clr_ovf(1'b0),
        .out(out8), .tc(tc8), .ovf(ovf8), .at_max(at_max8), .at_zero(at_zero8)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Reference behaviour expressed directly in terms of count-range arithmetic.
    task automatic step_model();
        int hit;
        if (load) begin
            m_out = (int'(load_val) > MAXV) ? MAXV : int'(load_val);
            m_tc  = 0;
            if (clr_ovf) m_ovf = 0;
        end else if (!en) begin
            m_tc = 0;
            if (clr_ovf) m_ovf = 0;
        end else begin
            hit = up_dn ? int'(m_out == MAXV) : int'(m_out == 0);
            if (hit != 0) begin
                m_tc  = 1;
                m_ovf = 1;
                if (!sat_mode)
                    m_out = up_dn ? (m_out + 1) % (MAXV + 1) : MAXV;
            end else begin
                m_tc  = 0;
                m_out = up_dn ? m_out + 1 : m_out - 1;
                if (clr_ovf) m_ovf = 0;
            end
        end
        if (en8) begin
            m8_tc  = int'(m8_out == MAXV8);
            m8_out = (m8_out + 1) % (MAXV8 + 1);
        end else begin
            m8_tc = 0;
        end
    endtask

    task automatic check_all();
        check("out", 32'(out), m_out);
        check("tc", 32'(tc), m_tc);
        check("ovf", 32'(ovf), m_ovf);
        check("at_max", 32'(at_max), int'(m_out == MAXV));
        check("at_zero", 32'(at_zero), int'(m_out == 0));
        check("out8", 32'(out8), m8_out);
        check("tc8", 32'(tc8), m8_tc);
        check("at_max8", 32'(at_max8), int'(m8_out == MAXV8));
    endtask

    task automatic cyc();
        @(posedge clk);
        if (!rst) step_model();
        @(negedge clk);
        check_all();
    endtask

    // Reset pulse placed between clock edges; held across one edge with
    // load/en/clr_ovf active to show they are ignored.
    task automatic do_reset();
        #2 rst = 1'b1;
        #1;
        m_out = 0; m_tc = 0; m_ovf = 0;
        m8_out = RST8; m8_tc = 0;
        check("rst_out", 32'(out), 0);
        check("rst_tc", 32'(tc), 0);
        check("rst_ovf", 32'(ovf), 0);
        check("rst_out8", 32'(out8), RST8);
        load = 1'b1; load_val = 4'd5; en = 1'b1; clr_ovf = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("rst_hold_out", 32'(out), 0);
        check("rst_hold_tc", 32'(tc), 0);
        rst = 1'b0; load = 1'b0; en = 1'b0; clr_ovf = 1'b0;
    endtask

    int up_seq[12]   = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
    int dn_seq[4]    = '{1, 0, 0, 0};
    int dn_tc[4]     = '{0, 0, 1, 1};
    int seq8[6]      = '{251, 252, 253, 254, 255, 0};

    initial begin
        rst = 1'b0; en = 1'b0; up_dn = 1'b1; sat_mode = 1'b0;
        load = 1'b0; load_val = 4'd0; clr_ovf = 1'b0; en8 = 1'b0;
        m_out = 0; m_tc = 0; m_ovf = 0; m8_out = RST8; m8_tc = 0;
        @(negedge clk);
        do_reset();

        // Up count in wrap mode through one roll-over.
        en = 1'b1; up_dn = 1'b1; sat_mode = 1'b0;
        for (int i = 0; i < 12; i++) begin
            cyc();
            check("up_seq", 32'(out), up_seq[i]);
            check("up_tc", 32'(tc), int'(i == 9));
            check("up_ovf", 32'(ovf), int'(i >= 9));
        end

        // Mid-count asynchronous reset with ovf set.
        do_reset();

        // Down count saturating at zero.
        load = 1'b1; load_val = 4'd2; en = 1'b0;
        cyc();
        load = 1'b0; en = 1'b1; up_dn = 1'b0; sat_mode = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc();
            check("dn_seq", 32'(out), dn_seq[i]);
            check("dn_tc", 32'(tc), dn_tc[i]);
            check("dn_zero", 32'(at_zero), int'(i >= 1));
        end

        // Over-range load clamps, then wraps on the next up step.
        load = 1'b1; load_val = 4'd13; en = 1'b1; up_dn = 1'b1; sat_mode = 1'b0;
        cyc();
        check("clamp_out", 32'(out), 9);
        check("clamp_max", 32'(at_max), 1);
        check("clamp_tc", 32'(tc), 0);
        load = 1'b0;
        cyc();
        check("clamp_wrap_out", 32'(out), 0);
        check("clamp_wrap_tc", 32'(tc), 1);

        // Clear racing a boundary event, then a clear on its own.
        en = 1'b0; clr_ovf = 1'b1;
        cyc();
        check("clr_only_a", 32'(ovf), 0);
        clr_ovf = 1'b0; load = 1'b1; load_val = 4'd9;
        cyc();
        load = 1'b0; en = 1'b1; up_dn = 1'b1; clr_ovf = 1'b1;
        cyc();
        check("clr_vs_event", 32'(ovf), 1);
        en = 1'b0;
        cyc();
        check("clr_after", 32'(ovf), 0);
        clr_ovf = 1'b0;

        // Wide instance rolls over naturally from its reset value.
        do_reset();
        en8 = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cyc();
            check("seq8", 32'(out8), seq8[i]);
            check("tc8_seq", 32'(tc8), int'(i == 5));
        end
        en8 = 1'b0;

        // Random traffic with occasional asynchronous resets.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 49) == 0) begin
                do_reset();
            end else begin
                en       = 1'($urandom_range(0, 3) != 0);
                up_dn    = 1'($urandom_range(0, 1));
                sat_mode = 1'($urandom_range(0, 1));
                load     = 1'($urandom_range(0, 7) == 0);
                load_val = 4'($urandom_range(0, 15));
                clr_ovf  = 1'($urandom_range(0, 5) == 0);
                en8      = 1'($urandom_range(0, 1));
                cyc();
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/counter_param.md
COUNTER_PARAM -- requirements
Module: counter_param

Interface
REQ-001 SHALL have parameter WIDTH, default 4, counter bit width (legal 2..32).
REQ-002 SHALL have parameter MAX_VAL, default 15, upper count bound; legal range 1..2^WIDTH-1; count range 0..MAX_VAL.
REQ-003 SHALL have parameter RST_VAL, default 0, value loaded by reset; legal range 0..MAX_VAL.
REQ-004 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port en  input  1  count enable; 1 = step one count this cycle.
REQ-007 SHALL have port up_dn  input  1  direction; 1 = increment, 0 = decrement.
REQ-008 SHALL have port sat_mode  input  1  boundary mode; 1 = saturate, 0 = wrap.
REQ-009 SHALL have port load  input  1  synchronous load strobe.
REQ-010 SHALL have port load_val  input  WIDTH  value to load.
REQ-011 SHALL have port clr_ovf  input  1  synchronous clear of sticky overflow flag.
REQ-012 SHALL have port out  output  WIDTH  registered count value.
REQ-013 SHALL have port tc  output  1  registered terminal-count pulse.
REQ-014 SHALL have port ovf  output  1  registered sticky boundary-event flag.
REQ-015 SHALL have port at_max  output  1  combinational, high when out == MAX_VAL.
REQ-016 SHALL have port at_zero  output  1  combinational, high when out == 0.

Function
REQ-017 SHALL update out, tc and ovf only on rising clk edge when rst is low.
REQ-018 SHALL give load priority over en: load=1 -> out <= load_val, regardless of en/up_dn.
REQ-019 SHALL clamp a load value above MAX_VAL: out <= MAX_VAL; clamped load sets neither tc nor ovf.
REQ-020 SHALL hold out when load=0 and en=0; tc <= 0 that cycle.
REQ-021 SHALL, with en=1, up_dn=1, out < MAX_VAL: out <= out+1, single-cycle latency.
REQ-022 SHALL, with en=1, up_dn=0, out > 0: out <= out-1, single-cycle latency.
REQ-023 SHALL define a boundary event as en=1, load=0 and either (up_dn=1, out==MAX_VAL) or (up_dn=0, out==0).
REQ-024 SHALL on a boundary event in wrap mode: up -> out <= 0; down -> out <= MAX_VAL.
REQ-025 SHALL on a boundary event in saturate mode hold out unchanged.
REQ-026 SHALL set tc <= 1 on the edge processing a boundary event, else tc <= 0 (one-cycle pulse per event; consecutive events give continuous high).
REQ-027 SHALL set ovf <= 1 on a boundary event; ovf holds until clr_ovf=1; simultaneous boundary event and clr_ovf -> ovf stays 1.
REQ-028 SHALL sample sat_mode and up_dn every cycle; mid-count changes take effect on the next edge with no extra latency.
REQ-029 SHALL keep all arithmetic within WIDTH bits; no intermediate value outside 0..MAX_VAL ever reaches out.
REQ-030 SHALL behave for MAX_VAL = 2^WIDTH-1 exactly as natural binary roll-over in wrap mode.

Reset
REQ-031 SHALL on rst=1, immediately and independent of clk: out = RST_VAL, tc = 0, ovf = 0.
REQ-032 SHALL hold reset values while rst=1, ignoring load, en and clr_ovf.
REQ-033 SHALL resume counting on the first rising clk edge after rst deasserts; reset asserted mid-count aborts the count with no residual tc pulse.

Verification (WIDTH=4, MAX_VAL=9, RST_VAL=0 unless noted)
REQ-034 SHALL cover: rst pulse between clk edges -> out=0, tc=0, ovf=0 before next edge.
REQ-035 SHALL cover: en=1, up, wrap, 12 edges from 0 -> out 1..9,0,1,2; tc high exactly one cycle when out becomes 0; ovf=1 thereafter.
REQ-036 SHALL cover: en=1, down, saturate from out=2 -> out 1,0,0,0; tc high on both holding cycles; at_zero=1 from out=0.
REQ-037 SHALL cover: load=1, load_val=13 with en=1 -> out=9, at_max=1, tc=0; next up edge in wrap mode -> out=0, tc=1.
REQ-038 SHALL cover: clr_ovf=1 on the same edge as a boundary event -> ovf remains 1; clr_ovf=1 alone next edge -> ovf=0.
REQ-039 SHALL cover: WIDTH=8, MAX_VAL=255, RST_VAL=250, up, wrap -> out 250..255,0; tc on roll-over to 0.
